muldiv_sequencer: RTL and testbench

//  Sequences the iterative Mult and Div units and the HI/LO registers of the multicycle MIPS datapath.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_sequencer_if.sv | 34 +++
 rtl/muldiv_lat_counter.sv | 36 +++
 rtl/muldiv_sequencer.sv | 119 +++++++++++
 tb/tb_muldiv_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mult/div sequencer.
// State encoding, HI/LO mux select values and default unit latencies.
package muldiv_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MULT_RUN  = 3'd1,
      DIV_RUN   = 3'd2,
      WRITEBACK = 3'd3,
      EXC       = 3'd4
   } state_e;

   localparam logic SEL_MULT = 1'b0;
   localparam logic SEL_DIV  = 1'b1;

   localparam int DEFAULT_MULT_LAT = 33;
   localparam int DEFAULT_DIV_LAT  = 33;
   localparam int DEFAULT_CNT_W    = 6;

   function automatic logic is_run(input state_e s);
      return (s == MULT_RUN) || (s == DIV_RUN);
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between ControlUnit and the mult/div sequencer.
// The master side is ControlUnit; the slave side is the sequencer.
interface muldiv_sequencer_if;

   logic        mult_req;
   logic        div_req;
   logic        hilo_rd;
   logic        flush;
   logic [31:0] op_b;

   logic        mult_start;
   logic        div_start;
   logic        mult_or_div_hi;
   logic        mult_or_div_lo;
   logic        hi_write;
   logic        lo_write;
   logic        busy;
   logic        stall;
   logic        done;
   logic        div_zero_exc;

   modport master (
      output mult_req, div_req, hilo_rd, flush, op_b,
      input  mult_start, div_start, mult_or_div_hi, mult_or_div_lo,
             hi_write, lo_write, busy, stall, done, div_zero_exc
   );

   modport slave (
      input  mult_req, div_req, hilo_rd, flush, op_b,
      output mult_start, div_start, mult_or_div_hi, mult_or_div_lo,
             hi_write, lo_write, busy, stall, done, div_zero_exc
   );

endinterface

// File: rtl/muldiv_lat_counter.sv
// Loadable down-counter that times the fixed Mult/Div unit latency.
// Holds at zero; load takes priority over decrement.
module muldiv_lat_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the iterative Mult/Div units and the HI/LO write of the multicycle MIPS datapath.
// Issues start pulses, times the unit latency, drives result selects and stalls ControlUnit while busy.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int MULT_LAT = DEFAULT_MULT_LAT,
   parameter int DIV_LAT  = DEFAULT_DIV_LAT,
   parameter int CNT_W    = DEFAULT_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   muldiv_sequencer_if.slave  bus
);

   localparam logic [CNT_W-1:0] MULT_CNT_INIT = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT_INIT  = CNT_W'(DIV_LAT - 1);

   state_e           state_q;
   state_e           state_d;
   logic             mult_start_q;
   logic             mult_start_d;
   logic             div_start_q;
   logic             div_start_d;
   logic             sel_q;
   logic             sel_d;

   logic             cnt_load;
   logic             cnt_en;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_zero;

   logic             busy;
   logic             wb_commit;

   muldiv_lat_counter #(
      .CNT_W (CNT_W)
   ) u_lat_counter (
      .clk      (clk),
      .rst_n    (reset),
      .load     (cnt_load),
      .en       (cnt_en),
      .load_val (cnt_load_val),
      .zero     (cnt_zero)
   );

   // Mult wins if both requests arrive together; a zero divisor never starts Div.
   always_comb begin
      state_d      = state_q;
      mult_start_d = 1'b0;
      div_start_d  = 1'b0;
      sel_d        = sel_q;
      cnt_load     = 1'b0;
      cnt_en       = 1'b0;
      cnt_load_val = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.mult_req) begin
               state_d      = MULT_RUN;
               mult_start_d = 1'b1;
               sel_d        = SEL_MULT;
               cnt_load     = 1'b1;
               cnt_load_val = MULT_CNT_INIT;
            end else if (bus.div_req) begin
               if (bus.op_b == 32'd0) begin
                  state_d = EXC;
               end else begin
                  state_d      = DIV_RUN;
                  div_start_d  = 1'b1;
                  sel_d        = SEL_DIV;
                  cnt_load     = 1'b1;
                  cnt_load_val = DIV_CNT_INIT;
               end
            end
         end
         MULT_RUN, DIV_RUN: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else if (cnt_zero) begin
               state_d = WRITEBACK;
            end else begin
               cnt_en = 1'b1;
            end
         end
         WRITEBACK: state_d = IDLE;
         EXC:       state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         mult_start_q <= 1'b0;
         div_start_q  <= 1'b0;
         sel_q        <= SEL_MULT;
      end else begin
         state_q      <= state_d;
         mult_start_q <= mult_start_d;
         div_start_q  <= div_start_d;
         sel_q        <= sel_d;
      end
   end

   // An exception flush in the writeback cycle must keep HI/LO from committing.
   assign wb_commit = (state_q == WRITEBACK) && !bus.flush;
   assign busy      = (state_q != IDLE);

   assign bus.mult_start     = mult_start_q;
   assign bus.div_start      = div_start_q;
   assign bus.mult_or_div_hi = sel_q;
   assign bus.mult_or_div_lo = sel_q;
   assign bus.hi_write       = wb_commit;
   assign bus.lo_write       = wb_commit;
   assign bus.done           = wb_commit;
   assign bus.busy           = busy;
   assign bus.div_zero_exc   = (state_q == EXC);
   assign bus.stall          = (bus.mult_req || bus.div_req || bus.hilo_rd) && busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand sequences
// for stall/back-to-back/reset, then random traffic against a cycle-numbered reference model.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int LAT = 33;

   logic clk = 1'b0;
   logic reset = 1'b0;

   muldiv_sequencer_if bus();

   muldiv_sequencer #(
      .MULT_LAT (LAT),
      .DIV_LAT  (LAT),
      .CNT_W    (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        mr;
      logic        dr;
      logic [31:0] b;
      int          flush_at;
      int          exp_mstart;
      int          exp_dstart;
      int          exp_wb;
      int          exp_exc;
      int          exp_idle;
      logic        exp_sel;
   } vec_t;

   vec_t vecs[8];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic mr, input logic dr, input logic hr,
                                 input logic fl, input logic [31:0] b);
      bus.mult_req = mr;
      bus.div_req  = dr;
      bus.hilo_rd  = hr;
      bus.flush    = fl;
      bus.op_b     = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller is at cycle 0 (idle); observes cycles 1..40 after a one-cycle request.
   task automatic run_vector(input vec_t v, input string tag);
      int ms_first = 0, ds_first = 0, wb_first = 0, exc_first = 0, idle_first = 0;
      int ms_cnt = 0, ds_cnt = 0, wb_cnt = 0, sel_err = 0, wr_err = 0;
      apply_stimulus(v.mr, v.dr, 1'b0, 1'b0, v.b);
      for (int c = 1; c <= 40; c++) begin
         tick();
         apply_stimulus(1'b0, 1'b0, 1'b0, (c == v.flush_at), v.b);
         #1;
         if (bus.mult_start) begin
            ms_cnt++;
            if (ms_first == 0) ms_first = c;
         end
         if (bus.div_start) begin
            ds_cnt++;
            if (ds_first == 0) ds_first = c;
         end
         if (bus.hi_write) begin
            wb_cnt++;
            if (wb_first == 0) wb_first = c;
         end
         if (bus.div_zero_exc && exc_first == 0) exc_first = c;
         if (!bus.busy && idle_first == 0) idle_first = c;
         if ((idle_first == 0 || idle_first == c) &&
             (bus.mult_or_div_hi !== v.exp_sel || bus.mult_or_div_lo !== v.exp_sel)) sel_err++;
         if (bus.lo_write !== bus.hi_write || bus.done !== bus.hi_write) wr_err++;
      end
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      check_output({tag, "_mult_start_cyc"}, ms_first, v.exp_mstart);
      check_output({tag, "_div_start_cyc"}, ds_first, v.exp_dstart);
      check_output({tag, "_start_pulses"}, ms_cnt + ds_cnt,
                   (v.exp_mstart != 0 ? 1 : 0) + (v.exp_dstart != 0 ? 1 : 0));
      check_output({tag, "_wb_cyc"}, wb_first, v.exp_wb);
      check_output({tag, "_wb_pulses"}, wb_cnt, (v.exp_wb != 0) ? 1 : 0);
      check_output({tag, "_exc_cyc"}, exc_first, v.exp_exc);
      check_output({tag, "_idle_cyc"}, idle_first, v.exp_idle);
      check_output({tag, "_sel_errs"}, sel_err, 0);
      check_output({tag, "_write_done_errs"}, wr_err, 0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int m_kind;
      int m_start;
      int rc;
      int age;
      logic m_sel;
      logic mr, dr, hr, fl;
      logic [31:0] b;
      logic [9:0] exp_v, act_v;
      int first_ds;

      vecs[0] = '{mr:1'b1, dr:1'b0, b:32'd5, flush_at:0,  exp_mstart:1, exp_dstart:0, exp_wb:34, exp_exc:0, exp_idle:35, exp_sel:SEL_MULT};
      vecs[1] = '{mr:1'b0, dr:1'b1, b:32'd7, flush_at:0,  exp_mstart:0, exp_dstart:1, exp_wb:34, exp_exc:0, exp_idle:35, exp_sel:SEL_DIV};
      vecs[2] = '{mr:1'b0, dr:1'b1, b:32'd0, flush_at:0,  exp_mstart:0, exp_dstart:0, exp_wb:0,  exp_exc:1, exp_idle:2,  exp_sel:SEL_DIV};
      vecs[3] = '{mr:1'b1, dr:1'b1, b:32'd7, flush_at:0,  exp_mstart:1, exp_dstart:0, exp_wb:34, exp_exc:0, exp_idle:35, exp_sel:SEL_MULT};
      vecs[4] = '{mr:1'b0, dr:1'b1, b:32'd3, flush_at:20, exp_mstart:0, exp_dstart:1, exp_wb:0,  exp_exc:0, exp_idle:21, exp_sel:SEL_DIV};
      vecs[5] = '{mr:1'b1, dr:1'b0, b:32'd9, flush_at:34, exp_mstart:1, exp_dstart:0, exp_wb:0,  exp_exc:0, exp_idle:35, exp_sel:SEL_MULT};
      vecs[6] = '{mr:1'b0, dr:1'b1, b:32'd1, flush_at:33, exp_mstart:0, exp_dstart:1, exp_wb:0,  exp_exc:0, exp_idle:34, exp_sel:SEL_DIV};
      vecs[7] = '{mr:1'b1, dr:1'b0, b:32'd2, flush_at:1,  exp_mstart:1, exp_dstart:0, exp_wb:0,  exp_exc:0, exp_idle:2,  exp_sel:SEL_MULT};

      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      #12;
      check_output("reset_busy", bus.busy, 0);
      check_output("reset_stall", bus.stall, 0);
      check_output("reset_outputs",
                   {bus.mult_start, bus.div_start, bus.mult_or_div_hi, bus.mult_or_div_lo,
                    bus.hi_write, bus.lo_write, bus.done, bus.div_zero_exc}, 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      #2 reset = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_vector(vecs[i], $sformatf("vec%0d", i));
      end

      // hilo_rd held from cycle 5 of a mult
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      for (int c = 1; c <= 36; c++) begin
         tick();
         apply_stimulus(1'b0, 1'b0, (c >= 5 && c <= 35), 1'b0, 32'd0);
         #1;
         if (c >= 5 && c <= 35) begin
            check_output($sformatf("hilo_stall_c%0d", c), bus.stall, (c <= 34) ? 1 : 0);
         end
      end

      // div_req held during a mult is accepted on the first idle cycle
      first_ds = 0;
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd7);
      for (int c = 1; c <= 40; c++) begin
         tick();
         apply_stimulus(1'b0, (c <= 35), 1'b0, 1'b0, 32'd7);
         #1;
         if (c == 1 || c == 34 || c == 35) begin
            check_output($sformatf("b2b_stall_c%0d", c), bus.stall, (c <= 34) ? 1 : 0);
         end
         if (bus.div_start && first_ds == 0) first_ds = c;
      end
      check_output("b2b_div_start_cyc", first_ds, 36);
      for (int c = 0; c < 35; c++) tick();

      // asynchronous reset in cycle 10 of a div, then a clean mult restart
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd9);
      tick();
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd9);
      for (int c = 2; c <= 10; c++) tick();
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd9);
      #1;
      check_output("pre_reset_stall", bus.stall, 1);
      reset = 1'b0;
      #1;
      check_output("midop_reset_busy", bus.busy, 0);
      check_output("midop_reset_stall", bus.stall, 0);
      check_output("midop_reset_sel", {bus.mult_or_div_hi, bus.mult_or_div_lo}, 0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      check_output("held_reset_start", {bus.mult_start, bus.busy}, 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      #2 reset = 1'b1;
      tick();
      run_vector(vecs[0], "restart");

      // random traffic against a cycle-numbered transaction model
      m_kind  = 0;
      m_start = 0;
      m_sel   = SEL_MULT;
      rc      = 0;
      for (int i = 0; i < 3000 && bad < 20; i++) begin
         tick();
         rc++;
         mr = ($urandom % 8) == 0;
         dr = ($urandom % 8) == 0;
         hr = ($urandom % 4) == 0;
         fl = ($urandom % 32) == 0;
         b  = (($urandom % 4) == 0) ? 32'd0 : $urandom;
         apply_stimulus(mr, dr, hr, fl, b);
         #1;
         age = rc - m_start + 1;
         exp_v[9] = (m_kind == 1) && (age == 1);
         exp_v[8] = (m_kind == 2) && (age == 1);
         exp_v[7] = m_sel;
         exp_v[6] = m_sel;
         exp_v[5] = (m_kind == 1 || m_kind == 2) && (age == LAT + 1) && !fl;
         exp_v[4] = exp_v[5];
         exp_v[3] = exp_v[5];
         exp_v[2] = (m_kind != 0);
         exp_v[1] = (mr || dr || hr) && (m_kind != 0);
         exp_v[0] = (m_kind == 3);
         act_v = {bus.mult_start, bus.div_start, bus.mult_or_div_hi, bus.mult_or_div_lo,
                  bus.hi_write, bus.lo_write, bus.done, bus.busy, bus.stall, bus.div_zero_exc};
         check_output($sformatf("rand_c%0d", rc), act_v, exp_v);
         if (m_kind == 0) begin
            if (mr) begin
               m_kind = 1; m_start = rc + 1; m_sel = SEL_MULT;
            end else if (dr) begin
               m_start = rc + 1;
               if (b == 32'd0) begin
                  m_kind = 3;
               end else begin
                  m_kind = 2; m_sel = SEL_DIV;
               end
            end
         end else if (m_kind == 3) begin
            m_kind = 0;
         end else if (fl || age == LAT + 1) begin
            m_kind = 0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
